// File: rtl/router_reg_pkt_if.sv
// Beat-level handshake between packet source, register stage and FIFO port.
interface router_reg_pkt_if #(
  parameter int DW = 8
);
  logic          pkt_valid;
  logic [DW-1:0] data_in;
  logic          busy;
  logic          fifo_full;
  logic [DW-1:0] dout;
  logic          dout_wr;

  modport master (
    output pkt_valid, data_in, fifo_full,
    input  busy, dout, dout_wr
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    output busy, dout, dout_wr
  );
endinterface

// File: rtl/router_reg_pkt.sv
// Packet register stage: hold queue, length/checksum check, packet counters.
module router_reg_pkt #(
  parameter int DW         = 8,
  parameter int ADDR_BITS  = 2,
  parameter int HOLD_DEPTH = 4,
  parameter int CHECK_MODE = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  router_reg_pkt_if.slave      bus,
  output logic [ADDR_BITS-1:0] dest_addr,
  output logic                 parity_done,
  output logic                 parity_err,
  output logic                 len_err,
  output logic [7:0]           good_cnt,
  output logic [7:0]           err_cnt
);

  localparam int LW = DW - ADDR_BITS;
  localparam int CW = LW + 1;
  localparam int PW = $clog2(HOLD_DEPTH);
  localparam int QW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DROP,
    DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0]        mem [HOLD_DEPTH];
  logic [PW-1:0]        wp_q, wp_d, rp_q, rp_d;
  logic [QW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        dout_q, dout_d;
  logic                 wr_q, wr_d;
  logic [ADDR_BITS-1:0] dest_q, dest_d;
  logic                 pd_q, pd_d;
  logic                 pe_q, pe_d;
  logic                 le_q, le_d;
  logic [7:0]           good_q, good_d;
  logic [7:0]           err_q, err_d;
  logic [DW-1:0]        acc_q, acc_d;
  logic [LW-1:0]        len_q, len_d;
  logic [CW-1:0]        pcnt_q, pcnt_d;

  logic          busy, push, pop, hdr_ok, bad;
  logic [DW-1:0] acc_nx;

  always_comb begin
    busy   = (state_q == DRAIN) || (cnt_q == QW'(HOLD_DEPTH));
    pop    = (cnt_q != '0) && !bus.fifo_full;
    hdr_ok = bus.data_in[ADDR_BITS-1:0] != '1;
    acc_nx = (CHECK_MODE == 1) ? acc_q + bus.data_in
                               : acc_q ^ bus.data_in;
    bad    = 1'b0;
    push   = 1'b0;
    state_d = state_q;
    dest_d  = dest_q;
    pd_d    = pd_q;
    pe_d    = pe_q;
    le_d    = le_q;
    good_d  = good_q;
    err_d   = err_q;
    acc_d   = acc_q;
    len_d   = len_q;
    pcnt_d  = pcnt_q;

    unique case (state_q)
      IDLE: begin
        if (!busy && bus.pkt_valid) begin
          if (hdr_ok) begin
            push    = 1'b1;
            state_d = LOAD;
            dest_d  = bus.data_in[ADDR_BITS-1:0];
            len_d   = bus.data_in[DW-1:ADDR_BITS];
            acc_d   = bus.data_in;
            pcnt_d  = '0;
            pd_d    = 1'b0;
            pe_d    = 1'b0;
            le_d    = 1'b0;
          end else begin
            state_d = DROP;
          end
        end
      end
      LOAD: begin
        if (!busy) begin
          push = 1'b1;
          if (bus.pkt_valid) begin
            acc_d = acc_nx;
            if (pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;
          end else begin
            // check beat is forwarded too
            pd_d = 1'b1;
            pe_d = acc_q != bus.data_in;
            le_d = pcnt_q != CW'(len_q);
            bad  = pe_d || le_d;
            if (bad) err_d = err_q + 8'(err_q != 8'hFF);
            else     good_d = good_q + 8'(good_q != 8'hFF);
            state_d = DRAIN;
          end
        end
      end
      DROP: begin
        if (!busy && !bus.pkt_valid) state_d = IDLE;
      end
      DRAIN: begin
        if (cnt_q == '0 || (cnt_q == QW'(1) && pop)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wp_d   = push ? wp_q + 1'b1 : wp_q;
    rp_d   = pop  ? rp_q + 1'b1 : rp_q;
    dout_d = pop  ? mem[rp_q]   : dout_q;
    wr_d   = pop;
    cnt_d  = cnt_q + QW'(push) - QW'(pop);
  end

  always_ff @(posedge clock) begin
    if (push) mem[wp_q] <= bus.data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
      dest_q  <= '0;
      pd_q    <= 1'b0;
      pe_q    <= 1'b0;
      le_q    <= 1'b0;
      good_q  <= '0;
      err_q   <= '0;
      acc_q   <= '0;
      len_q   <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
      dest_q  <= dest_d;
      pd_q    <= pd_d;
      pe_q    <= pe_d;
      le_q    <= le_d;
      good_q  <= good_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign bus.busy    = busy;
  assign bus.dout    = dout_q;
  assign bus.dout_wr = wr_q;
  assign dest_addr   = dest_q;
  assign parity_done = pd_q;
  assign parity_err  = pe_q;
  assign len_err     = le_q;
  assign good_cnt    = good_q;
  assign err_cnt     = err_q;

endmodule
